// File: rtl/sun2_mem_arbiter_pkg.sv
// Shared definitions for the Sun-2 main-memory arbiter:
// FSM states, requester indices and one-hot grant masks.
package sun2_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int VID = 0;
  localparam int CPU = 1;
  localparam int DMA = 2;

  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_VID  = 3'b001 << VID;
  localparam logic [2:0] GNT_CPU  = 3'b001 << CPU;
  localparam logic [2:0] GNT_DMA  = 3'b001 << DMA;

endpackage

// File: rtl/sun2_mem_arbiter_rfsh.sv
// DRAM refresh interval timer with pending flag and
// sticky overrun indicator.
module sun2_mem_arbiter_rfsh #(
  parameter int RFSH_INT = 624
) (
  input  logic clk40,
  input  logic reset_n,
  input  logic clr_i,
  output logic pend_o,
  output logic ovr_o
);

  localparam int CW = (RFSH_INT > 1) ? $clog2(RFSH_INT) : 1;
  localparam logic [CW-1:0] LAST = CW'(RFSH_INT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          tick;

  // A tick always wins over a same-cycle clear so no refresh is lost.
  always_comb begin
    tick   = (cnt_q == LAST);
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    pend_d = tick | (pend_q & ~clr_i);
    ovr_d  = ovr_q | (tick & pend_q);
  end

  // Timer state registers.
  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend_o = pend_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/sun2_mem_arbiter.sv
// Sun-2 main-memory arbiter: video, CPU and DMA share one
// DRAM port, with periodic refresh cycles injected.
module sun2_mem_arbiter
  import sun2_mem_arbiter_pkg::*;
#(
  parameter int AW       = 23,
  parameter int DW       = 16,
  parameter int MEM_WAIT = 2,
  parameter int RFSH_INT = 624
) (
  input  logic          clk40,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_we,
  input  logic [1:0]    dma_be,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] rdata,
  output logic [2:0]    gnt,
  output logic          mem_cs,
  output logic          mem_rfsh,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          rfsh_ovr
);

  localparam logic [3:0] WLAST = 4'(MEM_WAIT - 1);

  state_e        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [2:0]    ack_q, ack_d;
  logic          rr_q, rr_d;
  logic          cs_q, cs_d;
  logic          rf_q, rf_d;
  logic          we_q, we_d;
  logic [1:0]    be_q, be_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rfsh_pend;
  logic          rfsh_clr;

  sun2_mem_arbiter_rfsh #(
    .RFSH_INT(RFSH_INT)
  ) u_rfsh (
    .clk40  (clk40),
    .reset_n(reset_n),
    .clr_i  (rfsh_clr),
    .pend_o (rfsh_pend),
    .ovr_o  (rfsh_ovr)
  );

  // Arbitration in IDLE, then a fixed ACCESS/WAIT/DONE sequence.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    rr_d     = rr_q;
    cs_d     = cs_q;
    rf_d     = rf_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    rfsh_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (vid_req) begin
          state_d = S_ACCESS;
          gnt_d   = GNT_VID;
          cs_d    = 1'b1;
          we_d    = 1'b0;
          be_d    = 2'b11;
          addr_d  = vid_addr;
        end else if (rfsh_pend) begin
          state_d = S_ACCESS;
          cs_d    = 1'b1;
          rf_d    = 1'b1;
          we_d    = 1'b0;
          be_d    = 2'b00;
        end else if (cpu_req && (!dma_req || !rr_q)) begin
          state_d = S_ACCESS;
          gnt_d   = GNT_CPU;
          cs_d    = 1'b1;
          we_d    = cpu_we;
          be_d    = cpu_be;
          addr_d  = cpu_addr;
          wd_d    = cpu_wdata;
          rr_d    = 1'b1;
        end else if (dma_req) begin
          state_d = S_ACCESS;
          gnt_d   = GNT_DMA;
          cs_d    = 1'b1;
          we_d    = dma_we;
          be_d    = dma_be;
          addr_d  = dma_addr;
          wd_d    = dma_wdata;
          rr_d    = 1'b0;
        end
      end
      S_ACCESS: begin
        wcnt_d  = WLAST;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = S_DONE;
          cs_d    = 1'b0;
          rf_d    = 1'b0;
          ack_d   = gnt_q;
          if (!rf_q && !we_q) rdata_d = mem_rdata;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        ack_d    = GNT_NONE;
        gnt_d    = GNT_NONE;
        rfsh_clr = (gnt_q == GNT_NONE);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and memory-port registers.
  always_ff @(posedge clk40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      gnt_q   <= GNT_NONE;
      ack_q   <= GNT_NONE;
      rr_q    <= 1'b0;
      cs_q    <= 1'b0;
      rf_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rr_q    <= rr_d;
      cs_q    <= cs_d;
      rf_q    <= rf_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
    end
  end

  assign vid_ack   = ack_q[VID];
  assign cpu_ack   = ack_q[CPU];
  assign dma_ack   = ack_q[DMA];
  assign gnt       = gnt_q;
  assign rdata     = rdata_q;
  assign mem_cs    = cs_q;
  assign mem_rfsh  = rf_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wd_q;

endmodule

// File: tb/tb_sun2_mem_arbiter.sv
// Scoreboard bench for sun2_mem_arbiter: main instance for
// arbitration, two short-interval instances for refresh.
module tb_sun2_mem_arbiter;

  localparam logic [2:0] GV = 3'b001;
  localparam logic [2:0] GC = 3'b010;
  localparam logic [2:0] GD = 3'b100;

  typedef struct {
    logic [2:0]  who;
    logic [22:0] addr;
    logic [15:0] data;
    logic        we;
    logic [1:0]  be;
    logic [15:0] wd;
    int          at;
  } exp_t;

  logic clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  logic reset_n;
  int   cyc = 0;
  always @(posedge clk40) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  // main instance
  logic        v_req, c_req, d_req;
  logic [22:0] v_addr, c_addr, d_addr;
  logic        c_we, d_we;
  logic [1:0]  c_be, d_be;
  logic [15:0] c_wd, d_wd;
  logic        m_vack, m_cack, m_dack;
  logic [15:0] m_rdata;
  logic [2:0]  m_gnt;
  logic        m_cs, m_rf, m_we, m_ovr;
  logic [1:0]  m_be;
  logic [22:0] m_addr;
  logic [15:0] m_wd, m_mrd;

  assign m_mrd = m_addr[15:0] ^ 16'hb6ef;

  sun2_mem_arbiter dut (
    .clk40(clk40), .reset_n(reset_n),
    .vid_req(v_req), .vid_addr(v_addr), .vid_ack(m_vack),
    .cpu_req(c_req), .cpu_addr(c_addr), .cpu_we(c_we),
    .cpu_be(c_be), .cpu_wdata(c_wd), .cpu_ack(m_cack),
    .dma_req(d_req), .dma_addr(d_addr), .dma_we(d_we),
    .dma_be(d_be), .dma_wdata(d_wd), .dma_ack(m_dack),
    .rdata(m_rdata), .gnt(m_gnt), .mem_cs(m_cs),
    .mem_rfsh(m_rf), .mem_we(m_we), .mem_be(m_be),
    .mem_addr(m_addr), .mem_wdata(m_wd),
    .mem_rdata(m_mrd), .rfsh_ovr(m_ovr)
  );

  // refresh-only instance, RFSH_INT=16
  logic        b_vack, b_cack, b_dack;
  logic [15:0] b_rdata;
  logic [2:0]  b_gnt;
  logic        b_cs, b_rf, b_we, b_ovr;
  logic [1:0]  b_be;
  logic [22:0] b_addr;
  logic [15:0] b_wd;

  sun2_mem_arbiter #(.RFSH_INT(16)) dut_b (
    .clk40(clk40), .reset_n(reset_n),
    .vid_req(1'b0), .vid_addr(23'd0), .vid_ack(b_vack),
    .cpu_req(1'b0), .cpu_addr(23'd0), .cpu_we(1'b0),
    .cpu_be(2'b00), .cpu_wdata(16'd0), .cpu_ack(b_cack),
    .dma_req(1'b0), .dma_addr(23'd0), .dma_we(1'b0),
    .dma_be(2'b00), .dma_wdata(16'd0), .dma_ack(b_dack),
    .rdata(b_rdata), .gnt(b_gnt), .mem_cs(b_cs),
    .mem_rfsh(b_rf), .mem_we(b_we), .mem_be(b_be),
    .mem_addr(b_addr), .mem_wdata(b_wd),
    .mem_rdata(16'h1234), .rfsh_ovr(b_ovr)
  );

  // continuous-video instance, RFSH_INT=8
  logic        x_vreq;
  logic [22:0] x_vaddr;
  logic        x_vack, x_cack, x_dack;
  logic [15:0] x_rdata;
  logic [2:0]  x_gnt;
  logic        x_cs, x_rf, x_we, x_ovr;
  logic [1:0]  x_be;
  logic [22:0] x_addr;
  logic [15:0] x_wd, x_mrd;

  assign x_mrd = x_addr[15:0] ^ 16'hb6ef;

  sun2_mem_arbiter #(.RFSH_INT(8)) dut_c (
    .clk40(clk40), .reset_n(reset_n),
    .vid_req(x_vreq), .vid_addr(x_vaddr), .vid_ack(x_vack),
    .cpu_req(1'b0), .cpu_addr(23'd0), .cpu_we(1'b0),
    .cpu_be(2'b00), .cpu_wdata(16'd0), .cpu_ack(x_cack),
    .dma_req(1'b0), .dma_addr(23'd0), .dma_we(1'b0),
    .dma_be(2'b00), .dma_wdata(16'd0), .dma_ack(x_dack),
    .rdata(x_rdata), .gnt(x_gnt), .mem_cs(x_cs),
    .mem_rfsh(x_rf), .mem_we(x_we), .mem_be(x_be),
    .mem_addr(x_addr), .mem_wdata(x_wd),
    .mem_rdata(x_mrd), .rfsh_ovr(x_ovr)
  );

  exp_t qm[$];
  int   qb_rf[$];
  int   qc_rf[$];
  int   qc_vid[$];
  logic chk_b = 1'b0;
  logic chk_c = 1'b0;
  int   b_acks = 0;
  logic b_prev = 1'b0;
  logic c_prev = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic go(int k);
    while (cyc < k) begin
      @(posedge clk40);
      #1;
    end
  endtask

  task automatic push(logic [2:0] who, logic [22:0] a,
                      logic [15:0] d, logic we, logic [1:0] be,
                      logic [15:0] wd, int at);
    exp_t e;
    e.who = who; e.addr = a; e.data = d;
    e.we = we; e.be = be; e.wd = wd; e.at = at;
    qm.push_back(e);
  endtask

  // main scoreboard monitor: one entry per ack pulse
  always @(negedge clk40) begin
    exp_t e;
    if (m_vack | m_cack | m_dack) begin
      if (qm.size() == 0) begin
        chk("main_unexpected_ack",
            32'({m_dack, m_cack, m_vack}), 32'd0);
      end else begin
        e = qm.pop_front();
        chk("ack_owner", 32'({m_dack, m_cack, m_vack}), 32'(e.who));
        chk("gnt", 32'(m_gnt), 32'(e.who));
        chk("mem_addr", 32'(m_addr), 32'(e.addr));
        chk("rdata", 32'(m_rdata), 32'(e.data));
        chk("mem_we", 32'(m_we), 32'(e.we));
        chk("ack_cycle", 32'(cyc), 32'(e.at));
        if (e.who != GV) chk("mem_be", 32'(m_be), 32'(e.be));
        if (e.we) chk("mem_wdata", 32'(m_wd), 32'(e.wd));
      end
    end
  end

  // refresh monitors for the two short-interval instances
  always @(negedge clk40) begin
    int t;
    if (b_vack | b_cack | b_dack) b_acks <= b_acks + 1;
    if (chk_b && b_rf && !b_prev) begin
      if (qb_rf.size() == 0) begin
        chk("b_unexpected_rfsh", 32'(cyc), 32'd0);
      end else begin
        t = qb_rf.pop_front();
        chk("b_rfsh_cycle", 32'(cyc), 32'(t));
        chk("b_rfsh_cs", 32'(b_cs), 32'd1);
        chk("b_rfsh_we", 32'(b_we), 32'd0);
        chk("b_rfsh_gnt", 32'(b_gnt), 32'd0);
      end
    end
    if (chk_c && x_rf && !c_prev) begin
      if (qc_rf.size() == 0) begin
        chk("c_unexpected_rfsh", 32'(cyc), 32'd0);
      end else begin
        t = qc_rf.pop_front();
        chk("c_rfsh_cycle", 32'(cyc), 32'(t));
        chk("c_rfsh_gnt", 32'(x_gnt), 32'd0);
      end
    end
    if (chk_c && x_vack) begin
      if (qc_vid.size() == 0) begin
        chk("c_unexpected_vack", 32'(cyc), 32'd0);
      end else begin
        t = qc_vid.pop_front();
        chk("c_vack_cycle", 32'(cyc), 32'(t));
        chk("c_vid_rdata", 32'(x_rdata), 32'h0000b7ef);
      end
    end
    b_prev <= b_rf;
    c_prev <= x_rf;
  end

  initial begin
    int k;
    int r;
    reset_n = 1'b1;
    v_req = 0; c_req = 0; d_req = 0;
    v_addr = '0; c_addr = '0; d_addr = '0;
    c_we = 0; d_we = 0; c_be = 2'b11; d_be = 2'b11;
    c_wd = '0; d_wd = '0;
    x_vreq = 0; x_vaddr = '0;
    #2 reset_n = 1'b0;
    go(2);
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_cs", 32'(m_cs), 32'd0);
    chk("rst_rfsh", 32'(m_rf), 32'd0);
    chk("rst_acks", 32'({m_dack, m_cack, m_vack}), 32'd0);
    chk("rst_rdata", 32'(m_rdata), 32'd0);
    chk("rst_ovr", 32'(m_ovr), 32'd0);
    chk("rst_addr", 32'(m_addr), 32'd0);
    go(3);
    reset_n = 1'b1;

    // CPU and DMA together: CPU,DMA,CPU,DMA
    k = cyc;
    c_req = 1; c_addr = 23'h000010; c_we = 0; c_be = 2'b11;
    d_req = 1; d_addr = 23'h002000; d_we = 0; d_be = 2'b11;
    push(GC, 23'h000010, 16'hb6ff, 0, 2'b11, 16'h0, k + 4);
    push(GD, 23'h002000, 16'h96ef, 0, 2'b11, 16'h0, k + 9);
    push(GC, 23'h000010, 16'hb6ff, 0, 2'b11, 16'h0, k + 14);
    push(GD, 23'h002000, 16'h96ef, 0, 2'b11, 16'h0, k + 19);
    go(k + 15); c_req = 0;
    go(k + 20); d_req = 0;

    // single CPU read, 4-cycle latency
    k = cyc;
    c_req = 1; c_addr = 23'h000800;
    push(GC, 23'h000800, 16'hbeef, 0, 2'b11, 16'h0, k + 4);
    go(k + 5); c_req = 0;

    // video arrives during CPU WAIT, beats pending DMA
    k = cyc;
    c_req = 1; c_addr = 23'h000801;
    push(GC, 23'h000801, 16'hbeee, 0, 2'b11, 16'h0, k + 4);
    go(k + 2);
    v_req = 1; v_addr = 23'h000100;
    d_req = 1; d_addr = 23'h003000; d_we = 1; d_be = 2'b01;
    d_wd = 16'h1234;
    push(GV, 23'h000100, 16'hb7ef, 0, 2'b11, 16'h0, k + 9);
    push(GD, 23'h003000, 16'hb7ef, 1, 2'b01, 16'h1234, k + 14);
    go(k + 5); c_req = 0;
    go(k + 10); v_req = 0;
    go(k + 15); d_req = 0;

    // be=00 CPU write, then reset during a DMA write
    k = cyc;
    c_req = 1; c_addr = 23'h000004; c_we = 1; c_be = 2'b00;
    c_wd = 16'ha5a5;
    push(GC, 23'h000004, 16'hb7ef, 1, 2'b00, 16'ha5a5, k + 4);
    go(k + 5);
    c_req = 0;
    d_req = 1; d_addr = 23'h003002; d_we = 1; d_be = 2'b11;
    d_wd = 16'h5a5a;
    go(k + 7);
    chk("dma_wait_cs", 32'(m_cs), 32'd1);
    chk("dma_wait_gnt", 32'(m_gnt), 32'(GD));
    reset_n = 1'b0;
    c_req = 1; c_addr = 23'h000800; c_we = 0; c_be = 2'b11;
    #1;
    chk("abort_cs", 32'(m_cs), 32'd0);
    chk("abort_gnt", 32'(m_gnt), 32'd0);
    chk("abort_dack", 32'(m_dack), 32'd0);
    chk("abort_rdata", 32'(m_rdata), 32'd0);
    go(k + 9);
    reset_n = 1'b1;
    push(GC, 23'h000800, 16'hbeef, 0, 2'b11, 16'h0, k + 13);
    push(GD, 23'h003002, 16'hbeef, 1, 2'b11, 16'h5a5a, k + 18);
    go(k + 14); c_req = 0;
    go(k + 19); d_req = 0;

    // refresh instances
    reset_n = 1'b0;
    x_vreq = 1; x_vaddr = 23'h000100;
    go(cyc + 2);
    reset_n = 1'b1;
    r = cyc;
    for (int i = 0; i < 4; i++) qb_rf.push_back(r + 17 + 16 * i);
    for (int i = 0; i < 5; i++) qc_vid.push_back(r + 4 + 5 * i);
    qc_rf.push_back(r + 26);
    chk_b = 1'b1;
    chk_c = 1'b1;
    go(r + 15);
    chk("c_ovr_before", 32'(x_ovr), 32'd0);
    go(r + 17);
    chk("c_ovr_after", 32'(x_ovr), 32'd1);
    go(r + 25);
    x_vreq = 0;
    go(r + 31);
    chk_c = 1'b0;
    go(r + 70);
    chk_b = 1'b0;

    chk("main_queue_empty", 32'(qm.size()), 32'd0);
    chk("b_queue_empty", 32'(qb_rf.size()), 32'd0);
    chk("c_rf_queue_empty", 32'(qc_rf.size()), 32'd0);
    chk("c_vid_queue_empty", 32'(qc_vid.size()), 32'd0);
    chk("b_no_acks", 32'(b_acks), 32'd0);
    chk("b_rdata_kept", 32'(b_rdata), 32'd0);
    chk("b_no_ovr", 32'(b_ovr), 32'd0);
    chk("c_ovr_sticky", 32'(x_ovr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
